// File: rtl/channel_pkg.sv
// Shared state type, default geometry and pixel clamp for the channel
// affine SRAM engine.
package channel_pkg;

    localparam int NCH_DEF    = 3;
    localparam int PIX_W_DEF  = 8;
    localparam int ADDR_W_DEF = 20;
    localparam int GAIN_W_DEF = 12;
    localparam int FRAC_W_DEF = 8;
    localparam int DIM_W      = 10;
    localparam int WORD_W     = 16;
    localparam int SUM_W      = 32;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CALC,
        WRITE,
        DONE
    } chan_state_t;

    function automatic int clamp_pix(
        input int v,
        input int pix_w
    );
        int hi;
        hi = (1 << pix_w) - 1;
        if (v < 0) begin
            return 0;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/channel_affine_alu.sv
// Per-word affine transfer: (in - mean_s) * gain, rounded, plus mean_t,
// clamped to the pixel range and registered when i_en is high.
module channel_affine_alu
    import channel_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int GAIN_W = GAIN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [PIX_W-1:0]  i_pix,
    input  logic [PIX_W-1:0]  i_mean_s,
    input  logic [PIX_W-1:0]  i_mean_t,
    input  logic [GAIN_W-1:0] i_gain,
    output logic [PIX_W-1:0]  o_res
);

    localparam int PW  = PIX_W + GAIN_W + 2;
    localparam int RND = 1 << (FRAC_W - 1);

    logic signed [PIX_W:0]  d;
    logic signed [GAIN_W:0] g_s;
    logic signed [PIX_W:0]  mt_s;
    logic signed [PW-1:0]   p;
    logic signed [PW-1:0]   r;
    logic [PIX_W-1:0]       res_d;

    assign d    = $signed({1'b0, i_pix}) - $signed({1'b0, i_mean_s});
    assign g_s  = $signed({1'b0, i_gain});
    assign mt_s = $signed({1'b0, i_mean_t});

    // p stays wide enough for the full signed product plus rounding
    assign p = PW'(d) * PW'(g_s) + PW'(RND);
    assign r = (p >>> FRAC_W) + PW'(mt_s);

    assign res_d = PIX_W'(clamp_pix(int'(r), PIX_W));

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_res <= '0;
        end else if (i_en) begin
            o_res <= res_d;
        end
    end

endmodule

// File: rtl/channel_affine_sram.sv
// Channel-interleaved affine colour transfer over a single-port SRAM.
// Define CH_STATS_EN to enable per-channel output sum accumulators.
module channel_affine_sram
    import channel_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int GAIN_W = GAIN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [DIM_W-1:0]      i_cols,
    input  logic [DIM_W-1:0]      i_rows,
    input  logic [ADDR_W-1:0]     i_src_base,
    input  logic [ADDR_W-1:0]     i_dst_base,
    input  logic [NCH*PIX_W-1:0]  i_mean_s,
    input  logic [NCH*PIX_W-1:0]  i_mean_t,
    input  logic [NCH*GAIN_W-1:0] i_gain,
    output logic [ADDR_W-1:0]     o_sram_addr,
    output logic                  o_sram_oe_n,
    output logic                  o_sram_we_n,
    output logic [WORD_W-1:0]     o_sram_wdata,
    output logic                  o_sram_dq_oe,
    input  logic [WORD_W-1:0]     i_sram_rdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [NCH*SUM_W-1:0]  o_ch_sum
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    chan_state_t state_q;
    chan_state_t state_d;

    logic [DIM_W-1:0]  cols_q;
    logic [DIM_W-1:0]  rows_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [PIX_W-1:0]  ms_q [NCH];
    logic [PIX_W-1:0]  mt_q [NCH];
    logic [GAIN_W-1:0] g_q  [NCH];

    logic [CH_W-1:0]   ch_q;
    logic [DIM_W-1:0]  col_q;
    logic [DIM_W-1:0]  row_q;
    logic [ADDR_W-1:0] word_q;

    logic              dims_zero;
    logic              start_ok;
    logic              wr_fire;
    logic              ch_last;
    logic              col_last;
    logic              row_last;
    logic              last_word;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [PIX_W-1:0]  alu_res;
    logic              unused_rdata;

    assign unused_rdata = ^i_sram_rdata[WORD_W-1:PIX_W];

    assign dims_zero = (i_cols == '0) || (i_rows == '0);
    assign start_ok  = (state_q == IDLE) && i_start;
    assign wr_fire   = (state_q == WRITE) && !i_abort;

    assign ch_last   = ch_q == CH_W'(NCH - 1);
    assign col_last  = col_q == (cols_q - DIM_W'(1));
    assign row_last  = row_q == (rows_q - DIM_W'(1));
    assign last_word = ch_last && col_last && row_last;

    // word_q walks base + pix*NCH + ch directly
    assign src_addr = src_q + word_q;
    assign dst_addr = dst_q + word_q;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        o_sram_addr  = '0;
        o_sram_oe_n  = 1'b1;
        o_sram_we_n  = 1'b1;
        o_sram_dq_oe = 1'b0;
        o_sram_wdata = '0;
        o_done       = 1'b0;
        o_busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = dims_zero ? DONE : READ;
                end
            end
            READ: begin
                o_sram_addr = src_addr;
                o_sram_oe_n = 1'b0;
                state_d     = WAIT;
            end
            WAIT: begin
                o_sram_addr = src_addr;
                state_d     = CALC;
            end
            CALC: begin
                o_sram_addr = dst_addr;
                state_d     = WRITE;
            end
            WRITE: begin
                o_sram_addr  = dst_addr;
                o_sram_wdata = WORD_W'(alu_res);
                o_sram_we_n  = 1'b0;
                o_sram_dq_oe = 1'b1;
                state_d      = last_word ? DONE : READ;
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // abort wins over any strobe issued this cycle
        if (i_abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            o_sram_oe_n  = 1'b1;
            o_sram_we_n  = 1'b1;
            o_sram_dq_oe = 1'b0;
            o_done       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            cols_q <= '0;
            rows_q <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            for (int c = 0; c < NCH; c++) begin
                ms_q[c] <= '0;
                mt_q[c] <= '0;
                g_q[c]  <= '0;
            end
            ch_q   <= '0;
            col_q  <= '0;
            row_q  <= '0;
            word_q <= '0;
        end else if (start_ok) begin
            cols_q <= i_cols;
            rows_q <= i_rows;
            src_q  <= i_src_base;
            dst_q  <= i_dst_base;
            for (int c = 0; c < NCH; c++) begin
                ms_q[c] <= i_mean_s[c*PIX_W +: PIX_W];
                mt_q[c] <= i_mean_t[c*PIX_W +: PIX_W];
                g_q[c]  <= i_gain[c*GAIN_W +: GAIN_W];
            end
            ch_q   <= '0;
            col_q  <= '0;
            row_q  <= '0;
            word_q <= '0;
        end else if (wr_fire) begin
            word_q <= word_q + ADDR_W'(1);
            if (ch_last) begin
                ch_q <= '0;
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_q + DIM_W'(1);
                end else begin
                    col_q <= col_q + DIM_W'(1);
                end
            end else begin
                ch_q <= ch_q + CH_W'(1);
            end
        end
    end

    channel_affine_alu #(
        .PIX_W  (PIX_W),
        .GAIN_W (GAIN_W),
        .FRAC_W (FRAC_W)
    ) u_alu (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_en     (state_q == WAIT),
        .i_pix    (i_sram_rdata[PIX_W-1:0]),
        .i_mean_s (ms_q[ch_q]),
        .i_mean_t (mt_q[ch_q]),
        .i_gain   (g_q[ch_q]),
        .o_res    (alu_res)
    );

`ifdef CH_STATS_EN
    logic [SUM_W-1:0] sum_q [NCH];

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < NCH; c++) begin
                sum_q[c] <= '0;
            end
        end else if (start_ok) begin
            for (int c = 0; c < NCH; c++) begin
                sum_q[c] <= '0;
            end
        end else if (wr_fire) begin
            sum_q[ch_q] <= sum_q[ch_q] + SUM_W'(alu_res);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_sum
        assign o_ch_sum[c*SUM_W +: SUM_W] = sum_q[c];
    end
`else
    assign o_ch_sum = '0;
`endif

endmodule

// File: tb/tb_channel_affine_sram.sv
// Randomised bench for channel_affine_sram against an arithmetic model
// of the colour transfer and an SRAM model holding the image.
module tb_channel_affine_sram;

    localparam int NCH    = 3;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 20;
    localparam int GAIN_W = 12;
    localparam int FRAC_W = 8;

    logic                  clk = 1'b0;
    logic                  i_rst;
    logic                  i_start;
    logic                  i_abort;
    logic [9:0]            i_cols;
    logic [9:0]            i_rows;
    logic [ADDR_W-1:0]     i_src_base;
    logic [ADDR_W-1:0]     i_dst_base;
    logic [NCH*PIX_W-1:0]  i_mean_s;
    logic [NCH*PIX_W-1:0]  i_mean_t;
    logic [NCH*GAIN_W-1:0] i_gain;
    logic [ADDR_W-1:0]     o_sram_addr;
    logic                  o_sram_oe_n;
    logic                  o_sram_we_n;
    logic [15:0]           o_sram_wdata;
    logic                  o_sram_dq_oe;
    logic [15:0]           i_sram_rdata = 16'h0;
    logic                  o_busy;
    logic                  o_done;
    logic [NCH*32-1:0]     o_ch_sum;

    channel_affine_sram #(
        .NCH    (NCH),
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W),
        .GAIN_W (GAIN_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .i_cols       (i_cols),
        .i_rows       (i_rows),
        .i_src_base   (i_src_base),
        .i_dst_base   (i_dst_base),
        .i_mean_s     (i_mean_s),
        .i_mean_t     (i_mean_t),
        .i_gain       (i_gain),
        .o_sram_addr  (o_sram_addr),
        .o_sram_oe_n  (o_sram_oe_n),
        .o_sram_we_n  (o_sram_we_n),
        .o_sram_wdata (o_sram_wdata),
        .o_sram_dq_oe (o_sram_dq_oe),
        .i_sram_rdata (i_sram_rdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_ch_sum     (o_ch_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int val;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          done_lat = -1;
    int          rd_lat = -1;
    int          acc_cnt = 0;
    int          wr_cnt = 0;
    logic [15:0] mem [int];
    wr_t         expq [$];

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int affine(input int x, input int ms,
                                  input int mt, input int g);
        int p;
        int r;
        p = (x - ms) * g + (1 << (FRAC_W - 1));
        r = (p >>> FRAC_W) + mt;
        if (r < 0) return 0;
        if (r > (1 << PIX_W) - 1) return (1 << PIX_W) - 1;
        return r;
    endfunction

    function automatic int rd_mem(input int a);
        logic [15:0] w;
        w = mem.exists(a) ? mem[a] : 16'h0;
        return int'(w[PIX_W-1:0]);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!o_sram_oe_n) begin
            i_sram_rdata <= mem.exists(int'(o_sram_addr)) ?
                            mem[int'(o_sram_addr)] : 16'h0;
        end
        if (!o_sram_we_n) begin
            mem[int'(o_sram_addr)] = o_sram_wdata;
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (!i_rst) begin
            chk("oe_we_exclusive",
                longint'(!o_sram_oe_n && !o_sram_we_n), 0);
            if (!o_sram_oe_n || !o_sram_we_n) acc_cnt++;
            if (!o_sram_oe_n && rd_lat < 0) rd_lat = cyc - start_cyc;
            if (!o_sram_we_n) begin
                wr_cnt++;
                chk("wr_dq_oe", longint'(o_sram_dq_oe), 1);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0d, none required",
                             o_sram_addr, o_sram_wdata);
                end else begin
                    e = expq.pop_front();
                    chk("wr_addr", longint'(o_sram_addr), e.addr);
                    chk("wr_data", longint'(o_sram_wdata), e.val);
                end
            end
            if (o_done) begin
                done_cnt++;
                done_lat = cyc - start_cyc;
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, longint'(o_busy), 0);
        chk({tag, "_done"}, longint'(o_done), 0);
        chk({tag, "_oe_n"}, longint'(o_sram_oe_n), 1);
        chk({tag, "_we_n"}, longint'(o_sram_we_n), 1);
        chk({tag, "_dq_oe"}, longint'(o_sram_dq_oe), 0);
        chk({tag, "_addr"}, longint'(o_sram_addr), 0);
        chk({tag, "_wdata"}, longint'(o_sram_wdata), 0);
        chk({tag, "_sum"}, longint'(o_ch_sum == '0), 1);
    endtask

    task automatic drive_cfg(input int cols, input int rows,
                             input int src, input int dst,
                             input int ms[NCH], input int mt[NCH],
                             input int g[NCH]);
        i_cols     = 10'(cols);
        i_rows     = 10'(rows);
        i_src_base = ADDR_W'(src);
        i_dst_base = ADDR_W'(dst);
        for (int c = 0; c < NCH; c++) begin
            i_mean_s[c*PIX_W +: PIX_W] = PIX_W'(ms[c]);
            i_mean_t[c*PIX_W +: PIX_W] = PIX_W'(mt[c]);
            i_gain[c*GAIN_W +: GAIN_W] = GAIN_W'(g[c]);
        end
    endtask

    task automatic scramble();
        i_cols     = 10'($urandom);
        i_rows     = 10'($urandom);
        i_src_base = ADDR_W'($urandom);
        i_dst_base = ADDR_W'($urandom);
        i_mean_s   = NCH*PIX_W'($urandom);
        i_mean_t   = NCH*PIX_W'($urandom);
        i_gain     = NCH*GAIN_W'($urandom);
    endtask

    task automatic launch(input int cols, input int rows,
                          input int src, input int dst,
                          input int ms[NCH], input int mt[NCH],
                          input int g[NCH]);
        @(posedge clk); #2;
        drive_cfg(cols, rows, src, dst, ms, mt, g);
        i_start   = 1'b1;
        start_cyc = cyc;
        done_cnt  = 0;
        done_lat  = -1;
        rd_lat    = -1;
        acc_cnt   = 0;
        wr_cnt    = 0;
        @(posedge clk); #2;
        i_start = 1'b0;
        scramble();
    endtask

    task automatic run_pass(input int cols, input int rows,
                            input int src, input int dst,
                            input int ms[NCH], input int mt[NCH],
                            input int g[NCH], input int abort_c,
                            input string tag);
        int nw;
        int nexp;
        int v;
        int bound;
        int sum [NCH];
        nw   = cols * rows * NCH;
        nexp = nw;
        if (abort_c > 0 && (abort_c - 1) / 4 < nw) nexp = (abort_c - 1) / 4;
        for (int c = 0; c < NCH; c++) sum[c] = 0;
        for (int w = 0; w < nw; w++) begin
            v = affine(rd_mem(src + w), ms[w % NCH], mt[w % NCH], g[w % NCH]);
            sum[w % NCH] += v;
            if (w < nexp) expq.push_back('{dst + w, v});
        end
        launch(cols, rows, src, dst, ms, mt, g);
        if (abort_c > 0) begin
            while (cyc < start_cyc + abort_c) begin
                @(posedge clk); #2;
            end
            i_abort = 1'b1;
            @(posedge clk); #2;
            i_abort = 1'b0;
            chk({tag, "_idle_after_abort"}, longint'(o_busy), 0);
            repeat (20) begin
                @(posedge clk); #2;
            end
            chk({tag, "_no_done"}, done_cnt, 0);
            chk({tag, "_writes"}, wr_cnt, nexp);
        end else begin
            bound = 4 * nw + 20;
            while (done_cnt == 0 && bound > 0) begin
                @(posedge clk); #2;
                bound--;
            end
            chk({tag, "_done_count"}, done_cnt, 1);
            chk({tag, "_done_cycle"}, done_lat, 4 * nw + 1);
            if (nw > 0) chk({tag, "_first_read"}, rd_lat, 1);
            else chk({tag, "_no_access"}, acc_cnt, 0);
            chk({tag, "_idle"}, longint'(o_busy), 0);
            chk({tag, "_writes"}, wr_cnt, nw);
            for (int c = 0; c < NCH; c++) begin
`ifdef CH_STATS_EN
                chk({tag, "_sum"}, longint'(o_ch_sum[c*32 +: 32]), sum[c]);
`else
                chk({tag, "_sum"}, longint'(o_ch_sum[c*32 +: 32]), 0);
`endif
            end
        end
        chk({tag, "_queue_left"}, expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        int ms [NCH];
        int mt [NCH];
        int g  [NCH];
        int src;
        int dst;
        int cols;
        int rows;
        int bad;
        int bound;
        int wr_before;
        logic [15:0] w16;

        i_rst   = 1'b1;
        i_start = 1'b0;
        i_abort = 1'b0;
        drive_cfg(0, 0, 0, 0, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0});
        #1;
        chk_reset("reset_t0");
        repeat (3) @(posedge clk);
        #2;
        chk_reset("reset_held");
        i_rst = 1'b0;

        chk("model_shift", affine(120, 100, 50, 512), 90);
        chk("model_sat_hi", affine(250, 0, 0, 512), 255);
        chk("model_sat_lo", affine(10, 100, 0, 256), 0);
        chk("model_ident", affine(77, 40, 40, 256), 77);

        src = 'h100;
        dst = 'h800;
        for (int i = 0; i < 75; i++) begin
            w16 = 16'(src + i);
            mem[src + i] = {8'h00, w16[7:0]};
        end
        run_pass(5, 5, src, dst, '{40, 40, 40}, '{40, 40, 40},
                 '{256, 256, 256}, 0, "ident");
        chk("ident_done_301", done_lat, 301);
        bad = 0;
        for (int i = 0; i < 75; i++) begin
            if (mem[dst + i] !== mem[src + i]) bad++;
        end
        chk("ident_copy_mismatches", bad, 0);

        src = 'h2000;
        dst = 'h2100;
        mem[src]     = 16'hAB78;
        mem[src + 1] = 16'h00FA;
        mem[src + 2] = 16'h550A;
        run_pass(1, 1, src, dst, '{100, 0, 100}, '{50, 0, 0},
                 '{512, 512, 256}, 0, "literal");
        chk("literal_90", longint'(mem[dst]), 90);
        chk("literal_255", longint'(mem[dst + 1]), 255);
        chk("literal_0", longint'(mem[dst + 2]), 0);

        run_pass(0, 3, 'h3000, 'h3100, '{1, 2, 3}, '{4, 5, 6},
                 '{256, 256, 256}, 0, "zero_cols");
        run_pass(4, 0, 'h3000, 'h3100, '{1, 2, 3}, '{4, 5, 6},
                 '{256, 256, 256}, 0, "zero_rows");

        for (int k = 0; k < 6; k++) begin
            cols = $urandom_range(1, 4);
            rows = $urandom_range(1, 4);
            src  = 'h4000 + k * 'h1000;
            dst  = src + 'h800;
            for (int i = 0; i < cols * rows * NCH; i++) begin
                mem[src + i] = 16'($urandom);
            end
            for (int c = 0; c < NCH; c++) begin
                ms[c] = $urandom_range(0, 255);
                mt[c] = $urandom_range(0, 255);
                g[c]  = $urandom_range(0, 4095);
            end
            run_pass(cols, rows, src, dst, ms, mt, g, 0, "rand");
        end

        src = 'hA000;
        dst = 'hA800;
        for (int i = 0; i < 75; i++) mem[src + i] = 16'($urandom);
        run_pass(5, 5, src, dst, '{10, 20, 30}, '{90, 80, 70},
                 '{300, 200, 100}, 50, "abort50");
        run_pass(5, 5, src, dst, '{10, 20, 30}, '{90, 80, 70},
                 '{300, 200, 100}, 48, "abort_on_write");
        run_pass(5, 5, src, dst, '{10, 20, 30}, '{90, 80, 70},
                 '{300, 200, 100}, 0, "after_abort");

        for (int w = 0; w < 75; w++) begin
            expq.push_back('{dst + w, rd_mem(src + w)});
        end
        launch(5, 5, src, dst, '{0, 0, 0}, '{0, 0, 0},
               '{256, 256, 256});
        bound = 200;
        while (o_sram_we_n && bound > 0) begin
            @(posedge clk); #2;
            bound--;
        end
        chk("rst_write_reached", longint'(o_sram_we_n), 0);
        wr_before = wr_cnt;
        i_rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        expq.delete();
        repeat (3) @(posedge clk);
        #2;
        i_rst = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        chk("rst_no_resume", longint'(o_busy), 0);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_no_writes", wr_cnt, wr_before);

        src = 'hC000;
        dst = 'hC100;
        for (int i = 0; i < 12; i++) mem[src + i] = 16'd100;
        run_pass(2, 2, src, dst, '{0, 0, 0}, '{0, 0, 0},
                 '{256, 256, 256}, 0, "stats");
        for (int c = 0; c < NCH; c++) begin
`ifdef CH_STATS_EN
            chk("stats_400", longint'(o_ch_sum[c*32 +: 32]), 400);
`else
            chk("stats_tied0", longint'(o_ch_sum[c*32 +: 32]), 0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_affine_sram.md
CHANNEL_AFFINE_SRAM -- requirements
Module: channel_affine_sram

Interface
REQ-001 SHALL have parameter NCH, default 3: number of colour channels per pixel.
REQ-002 SHALL have parameter PIX_W, default 8: pixel bits, held in SRAM word bits [PIX_W-1:0].
REQ-003 SHALL have parameter ADDR_W, default 20: SRAM address width.
REQ-004 SHALL have parameter GAIN_W, default 12: unsigned gain width.
REQ-005 SHALL have parameter FRAC_W, default 8: gain fraction bits, so gain 256 means 1.0.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port i_start, input, 1 bit: begin a pass when idle.
REQ-009 SHALL have port i_abort, input, 1 bit: terminate the current pass.
REQ-010 SHALL have port i_cols, input, 10 bits, and port i_rows, input, 10 bits: image dimensions.
REQ-011 SHALL have port i_src_base, input, ADDR_W bits, and port i_dst_base, input, ADDR_W bits: base word addresses.
REQ-012 SHALL have ports i_mean_s, input, NCH x PIX_W bits, and i_mean_t, input, NCH x PIX_W bits: source and target means per channel.
REQ-013 SHALL have port i_gain, input, NCH x GAIN_W bits: per-channel gain (target std / source std).
REQ-014 SHALL have SRAM outputs: o_sram_addr (ADDR_W bits), o_sram_oe_n (1 bit), o_sram_we_n (1 bit), o_sram_wdata (16 bits), o_sram_dq_oe (1 bit, drive enable).
REQ-015 SHALL have input i_sram_rdata, 16 bits: SRAM read data.
REQ-016 SHALL have outputs o_busy (1 bit), o_done (1 bit, one-cycle pulse) and o_ch_sum (NCH x 32 bits).

Function
REQ-017 SHALL use channel-interleaved layout: word address = base + pix*NCH + ch, with pix = row*i_cols + col.
REQ-018 SHALL latch i_cols, i_rows, bases, means and gains on the start cycle; later input changes SHALL NOT affect the pass.
REQ-019 SHALL use FSM states IDLE, READ, WAIT, CALC, WRITE, DONE from package type chan_state_t.
REQ-020 SHALL move IDLE->READ on i_start; i_start SHALL be ignored in any other state.
REQ-021 SHALL make each channel word cost exactly 4 cycles: READ (oe_n=0, address = source) -> WAIT (capture rdata) -> CALC -> WRITE (we_n=0, dq_oe=1, address = destination).
REQ-022 SHALL, from WRITE, go to READ for the next word, or to DONE after the last word (ch=NCH-1, last pixel).
REQ-023 SHALL assert o_done for exactly one cycle in DONE, then return to IDLE; o_busy SHALL be 1 in every state except IDLE.
REQ-024 SHALL produce the first READ the cycle after start and o_done 4*i_cols*i_rows*NCH+1 cycles after start.
REQ-025 SHALL skip SRAM access when i_cols=0 or i_rows=0: IDLE->DONE directly, with o_done 1 cycle after start.
REQ-026 SHALL compute the result as d = in - mean_s (signed, PIX_W+1 bits), p = d*gain (signed) + 2^(FRAC_W-1), r = (p >>> FRAC_W) + mean_t.
REQ-027 SHALL clamp r to [0, 2^PIX_W-1]; o_sram_wdata SHALL be zero-extended r.
REQ-028 SHALL, on i_abort in any busy state, go to IDLE at the next edge with we_n=1, oe_n=1 and no o_done.
REQ-029 SHALL give i_abort priority over a write in the same cycle; that write SHALL be suppressed.
REQ-030 SHALL never assert o_sram_oe_n=0 and o_sram_we_n=0 in the same cycle.

Reset
REQ-031 SHALL, while i_rst=1, asynchronously force: state IDLE, o_busy=0, o_done=0, o_sram_oe_n=1, o_sram_we_n=1, o_sram_dq_oe=0, o_sram_addr=0, o_sram_wdata=0, o_ch_sum=0, all counters 0.
REQ-032 SHALL, on reset asserted mid-pass, leave the pass unfinished and not resume it; a new i_start is required.

Configuration
REQ-033 SHALL, with CH_STATS_EN defined, accumulate each channel's clamped output into o_ch_sum[ch]; sums clear on start and are valid from o_done until the next start.
REQ-034 SHALL, without CH_STATS_EN, keep o_ch_sum present but tied to 0 and omit the accumulators.

Structure
REQ-035 SHALL take chan_state_t, the default parameter constants and the clamp helper function from package channel_pkg.
REQ-036 SHALL place the arithmetic of REQ-026 and REQ-027 in sub-module channel_affine_alu, registered on the WAIT->CALC edge.

Verification
REQ-037 SHALL test: 5x5, NCH=3, gain=256, mean_s=mean_t=40, source = address low byte -> every destination word equals its source; o_done at cycle 301.
REQ-038 SHALL test: in=120, mean_s=100, mean_t=50, gain=512 -> written value 90.
REQ-039 SHALL test saturation: in=250, means=0, gain=512 -> 255; in=10, mean_s=100, mean_t=0, gain=256 -> 0.
REQ-040 SHALL test: i_cols=0 -> o_done 1 cycle after start, we_n and oe_n never low.
REQ-041 SHALL test: i_abort at cycle 50 of a 5x5 pass -> idle next cycle, no o_done, no further writes; a new start then completes normally.
REQ-042 SHALL test: i_rst pulsed during WRITE -> all outputs at reset values immediately; with CH_STATS_EN, a 2x2 all-100 identity pass gives o_ch_sum=400 per channel.
